// File: rtl/add_mul_comp_sub_seq_pkg.sv
// Shared opcode/state encodings and COMP result bit positions.
// Pure declarations: no latency or backpressure of its own.
package add_mul_comp_sub_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_MUL  = 2'd2,
      OP_COMP = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int COMP_GT_BIT = 0;
   localparam int COMP_EQ_BIT = 1;
   localparam int COMP_LT_BIT = 2;

endpackage

// File: rtl/seq_shift_add_mul.sv
// Unsigned shift-add multiplier: start loads operands, each step retires one multiplier bit.
// WIDTH steps per product; done is high during the final step, product is valid after that edge.
module seq_shift_add_mul #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         cnt     <= '0;
      end else if (start) begin
         mcand   <= {{WIDTH{1'b0}}, a};
         mplier  <= b;
         product <= '0;
         cnt     <= '0;
      end else if (step) begin
         if (mplier[0]) begin
            product <= product + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   // Combinational so the controller can leave MUL on the same edge as the last step.
   assign done = step && (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/add_mul_comp_sub_seq.sv
// ADD/SUB/COMP in one cycle, MUL in WIDTH+1 cycles via a shift-add sub-block; one command in flight.
// in_ready only in IDLE; result/out_valid held in DONE until out_ready, then one idle cycle.
module add_mul_comp_sub_seq
   import add_mul_comp_sub_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result
);

   state_e             state;
   op_e                op_in;
   op_e                op_q;
   logic [2*WIDTH-1:0] alu_nxt;
   logic [2*WIDTH-1:0] alu_q;
   logic               accept;
   logic               mul_start;
   logic               mul_step;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign op_in     = op_e'(op);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op_in == OP_MUL);
   assign mul_step  = (state == ST_MUL);

   always_comb begin
      alu_nxt = '0;
      case (op_in)
         OP_ADD:  alu_nxt = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
         // Subtracting in the wide domain yields the sign-extended difference directly.
         OP_SUB:  alu_nxt = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
         OP_COMP: begin
            alu_nxt[COMP_GT_BIT] = (a > b);
            alu_nxt[COMP_EQ_BIT] = (a == b);
            alu_nxt[COMP_LT_BIT] = (a < b);
         end
         default: alu_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         op_q      <= OP_ADD;
         alu_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q     <= op_in;
                  in_ready <= 1'b0;
                  if (op_in == OP_MUL) begin
                     state <= ST_MUL;
                  end else begin
                     alu_q     <= alu_nxt;
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .step    (mul_step),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Both sources are registers frozen outside an accept/step, so result holds through DONE.
   assign result = (op_q == OP_MUL) ? mul_product : alu_q;

endmodule
